// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Purpose  : Shared types and default constants for the parametrised serial
//             pattern detector (seq_detector_param) and its sub-blocks.
//  Contents : state_t  - detector FSM state encoding
//             len_t    - pattern-length type for the default MAX_LEN
//             DEF_*    - default parameter values
//  Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_HUNT = 2'd2
   } state_t;

   localparam int         DEF_MAX_LEN   = 8;
   localparam int         DEF_CNT_W     = 8;
   localparam logic [7:0] DEF_PATTERN_C = 8'b00101001;
   localparam int         DEF_LEN_C     = 6;
   localparam int         DEF_LEN_W     = $clog2(DEF_MAX_LEN + 1);

   typedef logic [DEF_LEN_W-1:0] len_t;

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_det_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_sat_cnt
//  Purpose  : Saturating event counter with synchronous clear and a sticky
//             saturation flag. Clear takes priority but still counts a
//             simultaneous increment, so clr+inc leaves the count at 1.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             i_clr         - clear count and saturation flag
//             i_inc         - count one event
//             o_cnt[CNT_W]  - current count, holds at all-ones
//             o_sat         - set when the count reaches all-ones
//  Revision : 1.0 - initial release
// ============================================================================
module seq_det_sat_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_sat
);

   localparam logic [CNT_W-1:0] c_ALL_ONES = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_cnt;
   logic             r_sat;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else if (i_clr) begin
         r_cnt <= CNT_W'(i_inc);
         r_sat <= 1'b0;
      end else if (i_inc) begin
         if (r_cnt != c_ALL_ONES) begin
            r_cnt <= r_cnt + 1'b1;
            // Flag as soon as the count lands on all-ones, not one event later.
            if ((r_cnt + 1'b1) == c_ALL_ONES) begin
               r_sat <= 1'b1;
            end
         end else begin
            r_sat <= 1'b1;
         end
      end
   end

   assign o_cnt = r_cnt;
   assign o_sat = r_sat;

endmodule : seq_det_sat_cnt
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Purpose  : Runtime-programmable serial pattern detector (1..MAX_LEN bits),
//             overlapping or non-overlapping matching, valid-qualified input,
//             one-cycle registered tone pulse per match, saturating counter.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             enable        - 1 = detect, 0 = idle (configuration writable)
//             cfg_pattern   - pattern, bit [len-1] received first
//             cfg_len       - pattern length (0 -> 1, >MAX_LEN -> MAX_LEN)
//             cfg_overlap   - 1 = overlapping matches allowed
//             bit_valid     - bit_in qualifier
//             bit_in        - serial data
//             cnt_clr       - clear match counter and saturation flag
//             tone          - one-cycle pulse per match
//             match_cnt     - saturating match count
//             cnt_sat       - sticky counter-saturated flag
//             busy          - detector in S_FILL or S_HUNT
//             irq, irq_ack  - only with SEQ_DET_IRQ_EN: sticky match
//                             interrupt and its acknowledge
//  Config   : SEQ_DET_IRQ_EN - adds the irq/irq_ack ports and logic
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN     = DEF_MAX_LEN,
   parameter int                 CNT_W       = DEF_CNT_W,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
   parameter int                 DEF_LEN     = DEF_LEN_C
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic [MAX_LEN-1:0]             cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
   input  logic                           cfg_overlap,
   input  logic                           bit_valid,
   input  logic                           bit_in,
   input  logic                           cnt_clr,
   output logic                           tone,
   output logic [CNT_W-1:0]               match_cnt,
   output logic                           cnt_sat,
`ifdef SEQ_DET_IRQ_EN
   output logic                           busy,
   output logic                           irq,
   input  logic                           irq_ack
`else
   output logic                           busy
`endif
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);

   state_t             r_state;
   logic [MAX_LEN-1:0] r_sr;
   logic [LEN_W-1:0]   r_fill;
   logic [MAX_LEN-1:0] r_pattern;
   logic [LEN_W-1:0]   r_len;
   logic               r_overlap;
   logic               r_tone;

   logic               w_acc;
   logic [MAX_LEN-1:0] w_sr_next;
   logic [MAX_LEN-1:0] w_mask;
   logic [LEN_W-1:0]   w_len_clamped;
   logic               w_full;
   logic               w_match;

   // ---------------------------------------------------------------------
   // Datapath: shift, length mask, compare
   // ---------------------------------------------------------------------
   assign w_acc     = bit_valid & (r_state != S_IDLE);
   assign w_sr_next = {r_sr[MAX_LEN-2:0], bit_in};

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         w_mask[i] = (i < int'(r_len));
      end
   end

   always_comb begin
      w_len_clamped = cfg_len;
      if (cfg_len == '0) begin
         w_len_clamped = LEN_W'(1);
      end else if (int'(cfg_len) > MAX_LEN) begin
         w_len_clamped = LEN_W'(MAX_LEN);
      end
   end

   // One bit wider so fill+1 cannot wrap when MAX_LEN+1 is a power of two.
   assign w_full  = ({1'b0, r_fill} + 1'b1) >= {1'b0, r_len};
   assign w_match = w_acc & w_full & (((w_sr_next ^ r_pattern) & w_mask) == '0);

   // ---------------------------------------------------------------------
   // FSM, shift register, configuration latch
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_sr      <= '0;
         r_fill    <= '0;
         r_pattern <= DEF_PATTERN;
         r_len     <= LEN_W'(DEF_LEN);
         r_overlap <= 1'b1;
         r_tone    <= 1'b0;
      end else begin
         // A match on the bit accepted while enable drops still pulses.
         r_tone <= w_match;

         if (r_state == S_IDLE) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_len_clamped;
            r_overlap <= cfg_overlap;
         end

         if (!enable) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_fill  <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_FILL;
               end
               S_FILL: begin
                  if (w_acc) begin
                     r_sr <= w_sr_next;
                     if (w_match && !r_overlap) begin
                        r_fill <= '0;
                     end else if (w_full) begin
                        r_fill  <= r_len;
                        r_state <= S_HUNT;
                     end else begin
                        r_fill <= r_fill + 1'b1;
                     end
                  end
               end
               S_HUNT: begin
                  if (w_acc) begin
                     r_sr <= w_sr_next;
                     // Non-overlap: the matched bits may not seed the next match.
                     if (w_match && !r_overlap) begin
                        r_fill  <= '0;
                        r_state <= S_FILL;
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // Match counter
   // ---------------------------------------------------------------------
   seq_det_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_sat_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (cnt_clr),
      .i_inc (w_match),
      .o_cnt (match_cnt),
      .o_sat (cnt_sat)
   );

`ifdef SEQ_DET_IRQ_EN
   logic r_irq;

   // Set wins over acknowledge so a match in the ack cycle is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq <= 1'b0;
      end else if (w_match) begin
         r_irq <= 1'b1;
      end else if (irq_ack) begin
         r_irq <= 1'b0;
      end
   end

   assign irq = r_irq;
`endif

   assign tone = r_tone;
   assign busy = (r_state != S_IDLE);

endmodule : seq_detector_param
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector_param
//  Purpose  : Self-checking bench for seq_detector_param (MAX_LEN=8, CNT_W=3).
//             A behavioural model keeps the history of accepted bits and
//             predicts tone/count/saturation/busy(/irq) for every cycle;
//             predictions are queued at drive time and compared after the edge.
//  Config   : SEQ_DET_IRQ_EN - also exercises irq/irq_ack
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 3;
   localparam int LEN_W   = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable;
   logic [7:0]       cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic             bit_valid;
   logic             bit_in;
   logic             cnt_clr;
   logic             tone;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;
   logic             busy;
`ifdef SEQ_DET_IRQ_EN
   logic             irq;
   logic             irq_ack;
`endif

   always #5 clk = ~clk;

   seq_detector_param #(
      .MAX_LEN     (MAX_LEN),
      .CNT_W       (CNT_W),
      .DEF_PATTERN (8'b00101001),
      .DEF_LEN     (6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .bit_valid   (bit_valid),
      .bit_in      (bit_in),
      .cnt_clr     (cnt_clr),
      .tone        (tone),
      .match_cnt   (match_cnt),
      .cnt_sat     (cnt_sat),
`ifdef SEQ_DET_IRQ_EN
      .busy        (busy),
      .irq         (irq),
      .irq_ack     (irq_ack)
`else
      .busy        (busy)
`endif
   );

   typedef struct {
      int tone;
      int cnt;
      int sat;
      int busy;
      int irq;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   bit       m_active;
   bit [7:0] m_pat;
   int       m_len;
   bit       m_ovl;
   int       m_cnt;
   bit       m_sat;
   bit       m_irq;
   bit       hist[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_cnt    = 0;
      m_sat    = 1'b0;
      m_irq    = 1'b0;
      hist.delete();
   endtask

   // One clock cycle: drive, predict, queue prediction, clock, compare.
   task automatic step(input bit en, input bit v, input bit b, input bit clr, input bit ack = 1'b0);
      bit   acc;
      bit   match;
      exp_t e;
      enable    = en;
      bit_valid = v;
      bit_in    = b;
      cnt_clr   = clr;
`ifdef SEQ_DET_IRQ_EN
      irq_ack   = ack;
`endif
      acc   = v && m_active;
      match = 1'b0;
      if (acc) begin
         hist.push_back(b);
         if (hist.size() > MAX_LEN) void'(hist.pop_front());
         if (hist.size() >= m_len) begin
            match = 1'b1;
            for (int i = 0; i < m_len; i++) begin
               if (hist[hist.size() - 1 - i] != m_pat[i]) match = 1'b0;
            end
         end
      end
      if (match && !m_ovl) hist.delete();
      if (clr) begin
         m_cnt = match ? 1 : 0;
         m_sat = 1'b0;
      end else if (match) begin
         if (m_cnt < 7) m_cnt++;
         if (m_cnt == 7) m_sat = 1'b1;
      end
      if (match) m_irq = 1'b1;
      else if (ack) m_irq = 1'b0;
      if (!m_active) begin
         m_pat = cfg_pattern;
         m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
         m_ovl = cfg_overlap;
      end
      if (!en) begin
         m_active = 1'b0;
         hist.delete();
      end else begin
         m_active = 1'b1;
      end
      e.tone = int'(match);
      e.cnt  = m_cnt;
      e.sat  = int'(m_sat);
      e.busy = int'(m_active);
      e.irq  = int'(m_irq);
      sb.push_back(e);

      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_eq("tone", 32'(tone), 32'(e.tone));
      check_eq("match_cnt", 32'(match_cnt), 32'(e.cnt));
      check_eq("cnt_sat", 32'(cnt_sat), 32'(e.sat));
      check_eq("busy", 32'(busy), 32'(e.busy));
`ifdef SEQ_DET_IRQ_EN
      check_eq("irq", 32'(irq), 32'(e.irq));
`endif
   endtask

   // Reset with every other input driven active to show reset wins.
   task automatic do_reset();
      rst       = 1'b1;
      enable    = 1'b1;
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      cnt_clr   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_tone", 32'(tone), 32'd0);
      check_eq("rst_cnt", 32'(match_cnt), 32'd0);
      check_eq("rst_sat", 32'(cnt_sat), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
`ifdef SEQ_DET_IRQ_EN
      check_eq("rst_irq", 32'(irq), 32'd0);
`endif
      rst = 1'b0;
      model_reset();
      sb.delete();
   endtask

   task automatic configure(input logic [7:0] pat, input logic [LEN_W-1:0] len, input bit ovl);
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Send bits val[n-1] .. val[0] with 'gap' idle cycles after each.
   task automatic send(input logic [7:0] val, input int n, input int gap);
      logic [7:0] v;
      v = val;
      for (int i = n - 1; i >= 0; i--) begin
         step(1'b1, 1'b1, v[i], 1'b0);
         repeat (gap) step(1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      rst         = 1'b1;
      enable      = 1'b0;
      cfg_pattern = 8'b00101001;
      cfg_len     = 4'd6;
      cfg_overlap = 1'b1;
      bit_valid   = 1'b0;
      bit_in      = 1'b0;
      cnt_clr     = 1'b0;
`ifdef SEQ_DET_IRQ_EN
      irq_ack     = 1'b0;
`endif
      model_reset();
      do_reset();

      // Default pattern, one match
      configure(8'b00101001, 4'd6, 1'b1);
      send(8'b00101001, 6, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);

      // 101 with and without overlap
      configure(8'b00000101, 4'd3, 1'b1);
      send(8'b00010101, 5, 0);
      configure(8'b00000101, 4'd3, 1'b0);
      send(8'b00010101, 5, 0);

      // Gaps of 5 invalid cycles are transparent
      configure(8'b00101001, 4'd6, 1'b1);
      send(8'b00101001, 6, 5);

      // Saturation with cfg_len = 0 (behaves as length 1, pattern bit0)
      configure(8'b00000001, 4'd0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (9) step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);

      // Length above MAX_LEN clamps to MAX_LEN
      configure(8'hA5, 4'd9, 1'b1);
      send(8'hA5, 8, 0);

      // Match on the same cycle enable falls
      configure(8'b00101001, 4'd6, 1'b1);
      send(8'b00010100, 5, 0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);

      // Reset mid-stream, then a full pattern yields exactly one pulse
      configure(8'b00101001, 4'd6, 1'b1);
      send(8'b00001010, 4, 0);
      do_reset();
      configure(8'b00101001, 4'd6, 1'b1);
      send(8'b00101001, 6, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);

`ifdef SEQ_DET_IRQ_EN
      // irq holds until acked; ack together with a match keeps it set
      configure(8'b00000001, 4'd1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_seq_detector_param
`default_nettype wire
